// File: rtl/mips_mc_ctrl_if.sv
// Signal bundle between the multi-cycle MIPS controller (master) and the datapath (slave).
interface mips_mc_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [4:0]       rt;
    logic             zero;
    logic             rs_ge0;
    logic             ir_we;
    logic             pc_we;
    logic [1:0]       npc_sel;
    logic             reg_we;
    logic [1:0]       reg_dst;
    logic [1:0]       wd_sel;
    logic [1:0]       alu_src;
    logic [2:0]       alu_op;
    logic             mem_re;
    logic             mem_we;
    logic             instr_done;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, funct, rt, zero, rs_ge0,
        output ir_we, pc_we, npc_sel, reg_we, reg_dst, wd_sel, alu_src, alu_op,
               mem_re, mem_we, instr_done, illegal, retired
    );

    modport slave (
        output opcode, funct, rt, zero, rs_ge0,
        input  ir_we, pc_we, npc_sel, reg_we, reg_dst, wd_sel, alu_src, alu_op,
               mem_re, mem_we, instr_done, illegal, retired
    );
endinterface

// File: rtl/mips_mc_ctrl.sv
// Five-state multi-cycle MIPS control unit with retired-instruction counter.
// Define MC_BGEZAL_EN to decode bgezal; otherwise that encoding is illegal.
module mips_mc_ctrl #(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 32
) (
    input  logic          clk,
    input  logic          reset,
    mips_mc_ctrl_if.master bus
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_e;
    typedef enum logic [3:0] {
        I_ADDU, I_SUBU, I_JR, I_NOP, I_ORI, I_LUI, I_LW, I_SW,
        I_BEQ, I_J, I_JAL, I_BGEZAL, I_ILL
    } instr_e;

    localparam logic [3:0] LAST_WAIT = 4'(MEM_LAT - 1);

    state_e           state_q, state_d;
    logic [3:0]       waitCnt_q, waitCnt_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             hold_q;
    instr_e           instr;
    logic             lastWait;

    logic       irWe, pcWe, regWe, memRe, memWe, instrDone, illegal;
    logic [1:0] npcSel, regDst, wdSel, aluSrc;
    logic [2:0] aluOp;

    assign lastWait = (waitCnt_q == LAST_WAIT);

    always_comb begin
        instr = I_ILL;
        case (bus.opcode)
            6'b000000: begin
                case (bus.funct)
                    6'b100001: instr = I_ADDU;
                    6'b100011: instr = I_SUBU;
                    6'b001000: instr = I_JR;
                    6'b000000: instr = I_NOP;
                    default:   instr = I_ILL;
                endcase
            end
            6'b001101: instr = I_ORI;
            6'b001111: instr = I_LUI;
            6'b100011: instr = I_LW;
            6'b101011: instr = I_SW;
            6'b000100: instr = I_BEQ;
            6'b000010: instr = I_J;
            6'b000011: instr = I_JAL;
`ifdef MC_BGEZAL_EN
            6'b000001: if (bus.rt == 5'b10001) instr = I_BGEZAL;
`endif
            default:   instr = I_ILL;
        endcase
    end

    // hold_q keeps everything quiet for the cycle after reset so FETCH restarts cleanly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            waitCnt_q <= '0;
            retired_q <= '0;
            hold_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            retired_q <= retired_d;
            hold_q    <= 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        irWe      = 1'b0;
        pcWe      = 1'b0;
        npcSel    = 2'b00;
        regWe     = 1'b0;
        regDst    = 2'b00;
        wdSel     = 2'b00;
        aluSrc    = 2'b00;
        aluOp     = 3'b000;
        memRe     = 1'b0;
        memWe     = 1'b0;
        instrDone = 1'b0;
        illegal   = 1'b0;

        if (!reset && !hold_q) begin
            case (state_q)
                S_FETCH: begin
                    if (lastWait) begin
                        irWe    = 1'b1;
                        pcWe    = 1'b1;
                        state_d = S_DECODE;
                    end else begin
                        waitCnt_d = waitCnt_q + 4'd1;
                    end
                end
                S_DECODE: state_d = S_EXEC;
                S_EXEC: begin
                    state_d   = S_FETCH;
                    instrDone = 1'b1;
                    case (instr)
                        I_ADDU, I_SUBU: begin
                            regDst    = 2'b01;
                            aluOp     = (instr == I_SUBU) ? 3'b001 : 3'b000;
                            instrDone = 1'b0;
                            state_d   = S_WB;
                        end
                        I_ORI, I_LUI: begin
                            aluSrc    = (instr == I_LUI) ? 2'b11 : 2'b10;
                            aluOp     = (instr == I_LUI) ? 3'b011 : 3'b010;
                            instrDone = 1'b0;
                            state_d   = S_WB;
                        end
                        I_LW, I_SW: begin
                            aluSrc    = 2'b01;
                            instrDone = 1'b0;
                            state_d   = S_MEM;
                        end
                        I_BEQ: begin
                            aluOp  = 3'b001;
                            pcWe   = bus.zero;
                            npcSel = 2'b01;
                        end
                        I_J: begin
                            pcWe   = 1'b1;
                            npcSel = 2'b10;
                        end
                        I_JAL: begin
                            pcWe   = 1'b1;
                            npcSel = 2'b10;
                            regWe  = 1'b1;
                            regDst = 2'b10;
                            wdSel  = 2'b10;
                        end
                        I_JR: begin
                            pcWe   = 1'b1;
                            npcSel = 2'b11;
                        end
                        I_BGEZAL: begin
                            pcWe   = bus.rs_ge0;
                            npcSel = 2'b01;
                            regWe  = 1'b1;
                            regDst = 2'b10;
                            wdSel  = 2'b10;
                        end
                        I_NOP:   ;
                        default: illegal = 1'b1;
                    endcase
                end
                S_MEM: begin
                    memRe = (instr == I_LW);
                    if (lastWait) begin
                        if (instr == I_LW) begin
                            state_d = S_WB;
                        end else begin
                            memWe     = 1'b1;
                            instrDone = 1'b1;
                            state_d   = S_FETCH;
                        end
                    end else begin
                        waitCnt_d = waitCnt_q + 4'd1;
                    end
                end
                S_WB: begin
                    regWe     = 1'b1;
                    wdSel     = (instr == I_LW) ? 2'b01 : 2'b00;
                    regDst    = (instr == I_ADDU || instr == I_SUBU) ? 2'b01 : 2'b00;
                    instrDone = 1'b1;
                    state_d   = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase

            if (state_d != state_q) waitCnt_d = '0;
        end
    end

    assign retired_d = instrDone ? retired_q + CNT_W'(1) : retired_q;

    assign bus.ir_we      = irWe;
    assign bus.pc_we      = pcWe;
    assign bus.npc_sel    = npcSel;
    assign bus.reg_we     = regWe;
    assign bus.reg_dst    = regDst;
    assign bus.wd_sel     = wdSel;
    assign bus.alu_src    = aluSrc;
    assign bus.alu_op     = aluOp;
    assign bus.mem_re     = memRe;
    assign bus.mem_we     = memWe;
    assign bus.instr_done = instrDone;
    assign bus.illegal    = illegal;
    assign bus.retired    = retired_q;
endmodule

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Multi-cycle control unit for the next-generation MIPS core. It replaces the single-cycle combinational decode with a five-state FSM (FETCH, DECODE, EXEC, MEM, WB) so that the instruction and data memories may take several cycles. It sits between the instruction register and the datapath muxes and write enables. It also keeps a retired-instruction counter.

## Interface
Parameters:
- MEM_LAT, 1, cycles per instruction/data memory access (legal range 1..15)
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- rt  in  5  IR[20:16]
- zero  in  1  ALU equality flag, rs==rt
- rs_ge0  in  1  rs[31]==0
- ir_we  out  1  load the instruction register
- pc_we  out  1  load the PC from the npc_sel source
- npc_sel  out  2  00 pc+4, 01 branch target, 10 jump target, 11 rs
- reg_we  out  1  GRF write enable
- reg_dst  out  2  00 rt, 01 rd, 10 $31
- wd_sel  out  2  00 ALU, 01 memory, 10 pc+4
- alu_src  out  2  00 rt, 01 sign-ext imm, 10 zero-ext imm, 11 imm<<16
- alu_op  out  3  000 add, 001 sub, 010 or, 011 pass B
- mem_re  out  1  data memory read
- mem_we  out  1  data memory write
- instr_done  out  1  one-cycle pulse when an instruction retires
- illegal  out  1  one-cycle pulse in EXEC for an unsupported encoding
- retired  out  CNT_W  number of instructions retired, wraps modulo 2^CNT_W

## Operation
- Supported instructions: addu (0/100001), subu (0/100011), jr (0/001000), nop (all-zero word, treated as sll; retires with no write), ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- FETCH: holds for MEM_LAT cycles using the wait counter. On the final cycle it asserts ir_we=1 and pc_we=1 with npc_sel=00. Then DECODE.
- DECODE: one cycle for the GRF read. All outputs are 0. Then EXEC.
- EXEC, R-type addu/subu: reg_dst=01, alu_src=00, alu_op=add/sub. Then WB.
- EXEC, ori: alu_src=10, alu_op=or. lui: alu_src=11, alu_op=011. Both go to WB.
- EXEC, lw/sw: alu_src=01, alu_op=add. Then MEM.
- EXEC, beq: alu_op=sub. pc_we=zero, npc_sel=01. Retires. Then FETCH.
- EXEC, j: pc_we=1, npc_sel=10. Retires.
- EXEC, jal: as j, plus reg_we=1, reg_dst=10, wd_sel=10. Retires.
- EXEC, jr: pc_we=1, npc_sel=11. Retires.
- EXEC, anything else: illegal=1, no writes. Retires (counted). Then FETCH.
- MEM: holds for MEM_LAT cycles. mem_re is held for all of them on lw. For sw, mem_we=1 only on the final cycle, then it retires and goes to FETCH. lw goes to WB.
- WB: reg_we=1 for one cycle. wd_sel=01 for lw, otherwise 00. reg_dst=00 for ori/lui/lw, 01 for R-type. Retires. Then FETCH.
- Retiring: instr_done=1 in the retiring cycle; retired increments on the following edge.
- Outputs are decoded from state and opcode. Unlisted outputs in a state are 0.

## Timing
- Reset: state=FETCH, wait counter=0, retired=0. Every output is 0 while reset is high and in the cycle after.
- Reset in mid-instruction abandons it with no write enables and no count. FETCH then restarts with a full MEM_LAT wait.
- CPI: beq/j/jal/jr/illegal take MEM_LAT+2 cycles. ALU ops take MEM_LAT+3. sw takes 2·MEM_LAT+2. lw takes 2·MEM_LAT+3.
- The wait counter is 4 bits. It clears on every state exit. MEM_LAT=1 means no hold.
- retired wraps from all-ones to 0 with no flag.
- ir_we and pc_we are never asserted together outside the final FETCH cycle.

## Configuration
- MC_BGEZAL_EN defined: bgezal (opcode 000001, rt=10001) is decoded in EXEC.
  - Always: reg_we=1, reg_dst=10, wd_sel=10 (unconditional link).
  - pc_we=rs_ge0, npc_sel=01.
  - Retires, then FETCH.
- Undefined: that encoding takes the illegal path.

## Test plan
- MEM_LAT=1, reset 2 cycles, then addu: ir_we/pc_we at cycle 1, reg_we with reg_dst=01 at cycle 4, retired=1.
- MEM_LAT=3, lw: mem_re is high for exactly 3 cycles; WB has wd_sel=01; instr_done occurs 9 cycles after FETCH entry.
- MEM_LAT=2, sw: mem_we is high for only the last MEM cycle; no reg_we at any point.
- beq with zero=0, then zero=1: pc_we=0, then pc_we=1 with npc_sel=01. jal gives reg_dst=10, wd_sel=10, npc_sel=10.
- opcode 111111: illegal pulses once and retired increments. With MC_BGEZAL_EN and rs_ge0=0: reg_we=1, pc_we=0.
- CNT_W=4: after 16 nops retired=0. Reset asserted in MEM of lw: no reg_we, retired unchanged, and FETCH restarts.
